// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED event scheduler.
// Holds the scheduler state encoding, width helper and default show/blank timings.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  localparam int unsigned DEF_HOLD_CYCLES = 10_000_000;
  localparam int unsigned DEF_GAP_CYCLES  = 2_500_000;

  // Ceiling log2, never below 1 so it can always size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, wrapping.
// Generic so other shared-resource blocks can reuse it.
module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        i_req,
  input  logic [clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]        o_gnt_c,
  output logic [clog2(N_REQ)-1:0] o_idx_c,
  output logic                    o_any_c
);

  localparam int unsigned IDX_W = clog2(N_REQ);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_cand;

  // Walk candidates from the pointer upward; the first hit wins.
  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_sum = SUM_W'(i_ptr) + SUM_W'(k);
      if (w_sum >= SUM_W'(N_REQ)) w_sum = w_sum - SUM_W'(N_REQ);
      w_cand = IDX_W'(w_sum);
      if (!o_any_c && i_req[w_cand]) begin
        o_any_c         = 1'b1;
        o_idx_c         = w_cand;
        o_gnt_c[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_event_sched.sv
// Shares the LED bank between event sources: edge-detect, latch pending,
// then show each granted source's pattern for HOLD_CYCLES followed by a GAP_CYCLES blank.
module led_event_sched
  import led_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned LED_W       = 4,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [N_REQ-1:0]         evt_in,
  input  logic [N_REQ*LED_W-1:0]   evt_pat,
  output logic [LED_W-1:0]         led_en,
  output logic                     busy,
  output logic [clog2(N_REQ)-1:0]  grant_id,
  output logic                     evt_drop,
  output logic [clog2(N_REQ)-1:0]  drop_id
);

  localparam int unsigned IDX_W   = clog2(N_REQ);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

  sched_state_e r_state;
  sched_state_e w_state_nxt;

  logic [N_REQ-1:0] r_d0;
  logic [N_REQ-1:0] r_d1;
  logic [N_REQ-1:0] r_pending;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [LED_W-1:0] r_led_en;
  logic             r_busy;
  logic [IDX_W-1:0] r_grant_id;
  logic             r_evt_drop;
  logic [IDX_W-1:0] r_drop_id;

  logic [N_REQ-1:0] w_flag;
  logic [N_REQ-1:0] w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_grant_now;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_drop;
  logic [N_REQ-1:0] w_pend_nxt;
  logic             w_drop_any;
  logic [IDX_W-1:0] w_drop_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LED_W-1:0] w_led_nxt;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [LED_W-1:0] w_pat [N_REQ];

  assign w_flag = r_d0 & ~r_d1;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_idx),
    .o_any_c (w_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_pat[i] = evt_pat[i*LED_W +: LED_W];
    end
  end

  // Scheduler next-state, counter and grant decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_led_nxt   = r_led_en;
    w_grant_nxt = r_grant_id;
    w_ptr_nxt   = r_ptr;
    w_grant_now = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = SHOW;
          w_grant_now = 1'b1;
          w_led_nxt   = w_pat[w_idx];
          w_grant_nxt = w_idx;
          w_ptr_nxt   = (w_idx == IDX_LAST) ? '0 : w_idx + IDX_W'(1);
          w_cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = GAP;
          w_led_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_led_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pending bookkeeping: a new edge beats the grant clear; an edge on an
  // already-pending, ungranted source is reported as a drop.
  always_comb begin
    w_clr      = w_grant_now ? w_gnt : '0;
    w_pend_nxt = w_flag | (r_pending & ~w_clr);
    w_drop     = w_flag & r_pending & ~w_clr;
    w_drop_any = 1'b0;
    w_drop_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_drop[i] && !w_drop_any) begin
        w_drop_any = 1'b1;
        w_drop_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_d0       <= '0;
      r_d1       <= '0;
      r_pending  <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_led_en   <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= '0;
      r_evt_drop <= 1'b0;
      r_drop_id  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_d0       <= evt_in;
      r_d1       <= r_d0;
      r_pending  <= w_pend_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_led_en   <= w_led_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_grant_id <= w_grant_nxt;
      r_evt_drop <= w_drop_any;
      r_drop_id  <= w_drop_idx;
    end
  end

  assign led_en   = r_led_en;
  assign busy     = r_busy;
  assign grant_id = r_grant_id;
  assign evt_drop = r_evt_drop;
  assign drop_id  = r_drop_id;

endmodule

// File: tb/tb_led_event_sched.sv
// Directed bench for led_event_sched with short HOLD/GAP timings.
// Steps are relative to the edge on which the stimulus was driven.
module tb_led_event_sched;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  evt_in;
  logic [15:0] evt_pat;
  logic [3:0]  led_en;
  logic        busy;
  logic [1:0]  grant_id;
  logic        evt_drop;
  logic [1:0]  drop_id;

  int checks;
  int errors;
  int drop_seen;

  led_event_sched #(
    .N_REQ       (4),
    .LED_W       (4),
    .HOLD_CYCLES (8),
    .GAP_CYCLES  (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .evt_in   (evt_in),
    .evt_pat  (evt_pat),
    .led_en   (led_en),
    .busy     (busy),
    .grant_id (grant_id),
    .evt_drop (evt_drop),
    .drop_id  (drop_id)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial drop_seen = 0;
  always @(negedge sys_clk) if (evt_drop === 1'b1) drop_seen <= drop_seen + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    sys_rst = 1'b1;
    evt_in  = 4'b0000;
    evt_pat = 16'h8431;
    tick(3);
    chk("rst_led", 32'(led_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_drop", 32'(evt_drop), 32'h0);
    chk("rst_drop_id", 32'(drop_id), 32'h0);
    sys_rst = 1'b0;
    tick(2);

    // Single event on source 1
    evt_in = 4'b0010;
    tick(2);
    chk("t1_not_yet", 32'(led_en), 32'h0);
    tick(1);
    chk("t1_lit", 32'(led_en), 32'h3);
    chk("t1_grant", 32'(grant_id), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    evt_in = 4'b0000;
    tick(7);
    chk("t1_last_lit", 32'(led_en), 32'h3);
    tick(1);
    chk("t1_off", 32'(led_en), 32'h0);
    chk("t1_busy_gap", 32'(busy), 32'h1);
    tick(3);
    chk("t1_gap_end_busy", 32'(busy), 32'h1);
    tick(1);
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_grant_hold", 32'(grant_id), 32'h1);

    sys_rst = 1'b1;
    tick(1);
    chk("rst2_grant", 32'(grant_id), 32'h0);
    sys_rst = 1'b0;
    tick(1);

    // Simultaneous events on 0, 2, 3 and fairness wrap
    evt_in = 4'b1101;
    tick(3);
    chk("t2_g0_led", 32'(led_en), 32'h1);
    chk("t2_g0_id", 32'(grant_id), 32'h0);
    evt_in = 4'b0000;
    tick(12);
    chk("t2_idle_led", 32'(led_en), 32'h0);
    chk("t2_idle_busy", 32'(busy), 32'h0);
    tick(1);
    chk("t2_g2_led", 32'(led_en), 32'h4);
    chk("t2_g2_id", 32'(grant_id), 32'h2);
    tick(13);
    chk("t2_g3_led", 32'(led_en), 32'h8);
    chk("t2_g3_id", 32'(grant_id), 32'h3);
    evt_in = 4'b1001;
    tick(3);
    evt_in = 4'b0000;
    tick(10);
    chk("t3_g0_led", 32'(led_en), 32'h1);
    chk("t3_g0_id", 32'(grant_id), 32'h0);
    tick(13);
    chk("t3_g3_led", 32'(led_en), 32'h8);
    chk("t3_g3_id", 32'(grant_id), 32'h3);
    tick(13);
    chk("t3_idle_busy", 32'(busy), 32'h0);
    chk("t3_idle_led", 32'(led_en), 32'h0);
    chk("t3_no_drops", 32'(drop_seen), 32'h0);

    // Overflow on source 2 while source 1 is shown
    evt_in = 4'b0010;
    tick(3);
    chk("t4_g1_led", 32'(led_en), 32'h3);
    evt_in = 4'b0000;
    tick(1);
    evt_in = 4'b0100;
    tick(2);
    evt_in = 4'b0000;
    tick(2);
    evt_in = 4'b0100;
    tick(1);
    chk("t4_drop_before", 32'(evt_drop), 32'h0);
    tick(1);
    chk("t4_drop", 32'(evt_drop), 32'h1);
    chk("t4_drop_id", 32'(drop_id), 32'h2);
    evt_in = 4'b0000;
    tick(1);
    chk("t4_drop_after", 32'(evt_drop), 32'h0);
    tick(5);
    chk("t4_g2_led", 32'(led_en), 32'h4);
    chk("t4_g2_id", 32'(grant_id), 32'h2);
    tick(14);
    chk("t4_one_show", 32'(busy), 32'h0);
    chk("t4_drop_count", 32'(drop_seen), 32'h1);

    // Re-trigger of source 1 during its own show, pattern changed mid-show
    evt_in = 4'b0010;
    tick(3);
    chk("t5_g1_led", 32'(led_en), 32'h3);
    chk("t5_g1_id", 32'(grant_id), 32'h1);
    evt_in = 4'b0000;
    tick(2);
    evt_pat = 16'h8461;
    evt_in  = 4'b0010;
    tick(1);
    chk("t5_pat_held_a", 32'(led_en), 32'h3);
    evt_in = 4'b0000;
    tick(1);
    tick(1);
    chk("t5_pat_held_b", 32'(led_en), 32'h3);
    tick(7);
    chk("t5_idle_busy", 32'(busy), 32'h0);
    tick(1);
    chk("t5_g1b_led", 32'(led_en), 32'h6);
    chk("t5_g1b_id", 32'(grant_id), 32'h1);
    chk("t5_drop_count", 32'(drop_seen), 32'h1);
    tick(14);

    // Reset mid-show with sources 1 and 3 pending
    evt_in = 4'b0001;
    tick(3);
    chk("t6_g0_led", 32'(led_en), 32'h1);
    chk("t6_g0_id", 32'(grant_id), 32'h0);
    evt_in = 4'b0000;
    tick(1);
    evt_in = 4'b1010;
    tick(3);
    evt_in = 4'b0000;
    tick(1);
    chk("t6_still_show", 32'(busy), 32'h1);
    sys_rst = 1'b1;
    tick(1);
    chk("t6_rst_led", 32'(led_en), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    sys_rst = 1'b0;
    tick(30);
    chk("t6_no_show_busy", 32'(busy), 32'h0);
    chk("t6_no_show_led", 32'(led_en), 32'h0);
    chk("t6_no_drop", 32'(evt_drop), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
